mm_seq: RTL and testbench

MM_SEQ -- requirements
Module: mm_seq

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_skew_sel.sv | 29 ++
 rtl/mm_seq.sv | 125 ++++++++++++
 tb/tb_mm_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared defaults, FSM state encoding and step-counter sizing for the matrix-multiply sequencer.
package mm_pkg;

  localparam int unsigned MmW = 16;
  localparam int unsigned MmN = 3;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StCapture,
    StDone
  } mm_state_e;

  // Step counter must hold 0..2n-2; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(2 * n - 1) : 1;
  endfunction

  localparam int unsigned MmKW = cnt_width(MmN);

endpackage

// File: rtl/mm_skew_sel.sv
// Skewed edge-operand selection: row i gets A[i][k-i], column j gets B[k-j][j], zero outside.
module mm_skew_sel #(
  parameter int unsigned W  = 16,
  parameter int unsigned N  = 3,
  parameter int unsigned KW = 3
) (
  input  logic [W*N*N-1:0] a_i,
  input  logic [W*N*N-1:0] b_i,
  input  logic [KW-1:0]    k_i,
  output logic [W*N-1:0]   a_row_o,
  output logic [W*N-1:0]   b_col_o
);

  // Pick the diagonal wavefront element for each edge lane at step k.
  always_comb begin
    int d;
    d       = 0;
    a_row_o = '0;
    b_col_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      d = int'(k_i) - i;
      if (d >= 0 && d < int'(N)) begin
        a_row_o[i*W +: W] = a_i[(i*int'(N)+d)*W +: W];
        b_col_o[i*W +: W] = b_i[(d*int'(N)+i)*W +: W];
      end
    end
  end

endmodule

// File: rtl/mm_seq.sv
// Job sequencer for an external NxN systolic array: snapshots operands, feeds skewed
// edge inputs, drains the pipeline and latches the accumulator matrix as the result.
module mm_seq
  import mm_pkg::*;
#(
  parameter int unsigned W = MmW,
  parameter int unsigned N = MmN
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W*N*N-1:0] i_A,
  input  logic [W*N*N-1:0] i_B,
  output logic [W*N-1:0]   o_a_row,
  output logic [W*N-1:0]   o_b_col,
  output logic             o_pe_en,
  output logic             o_pe_clr,
  input  logic [W*N*N-1:0] i_C,
  output logic [W*N*N-1:0] o_C,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy
);

  localparam int unsigned KW = cnt_width(N);
  localparam logic [KW-1:0] KFeedLast  = KW'(2 * N - 2);
  localparam logic [KW-1:0] KDrainLast = KW'((N > 1) ? (N - 2) : 0);
  localparam logic [KW-1:0] KOne       = KW'(1);

  mm_state_e          state_q;
  logic [KW-1:0]      k_q;
  logic [W*N*N-1:0]   a_q;
  logic [W*N*N-1:0]   b_q;
  logic               mode_q;
  logic [W*N*N-1:0]   c_q;
  logic               valid_q;
  logic [W*N-1:0]     a_sel;
  logic [W*N-1:0]     b_sel;

  mm_skew_sel #(
    .W  (W),
    .N  (N),
    .KW (KW)
  ) u_skew_sel (
    .a_i     (a_q),
    .b_i     (b_q),
    .k_i     (k_q),
    .a_row_o (a_sel),
    .b_col_o (b_sel)
  );

  // Job FSM with step counter, operand snapshot and result latch; i_en low freezes everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= '0;
      valid_q <= 1'b0;
    end else if (i_en) begin
      case (state_q)
        StIdle: begin
          if (i_valid) begin
            a_q     <= i_A;
            b_q     <= i_B;
            mode_q  <= i_mode;
            k_q     <= '0;
            state_q <= i_mode ? StFeed : StClear;
          end
        end
        StClear: begin
          k_q     <= '0;
          state_q <= StFeed;
        end
        StFeed: begin
          if (k_q == KFeedLast) begin
            k_q     <= '0;
            state_q <= (N > 1) ? StDrain : StCapture;
          end else begin
            k_q <= k_q + KOne;
          end
        end
        StDrain: begin
          if (k_q == KDrainLast) begin
            k_q     <= '0;
            state_q <= StCapture;
          end else begin
            k_q <= k_q + KOne;
          end
        end
        StCapture: begin
          c_q     <= i_C;
          valid_q <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and array control; pulses are masked while disabled so the array holds too.
  always_comb begin
    o_ready  = i_en & (state_q == StIdle);
    o_busy   = (state_q != StIdle);
    o_pe_en  = i_en & ((state_q == StFeed) | (state_q == StDrain));
    // Accumulate jobs never enter CLEAR; the mode gate only guards against a stray clear.
    o_pe_clr = i_en & (state_q == StClear) & ~mode_q;
    o_a_row  = (state_q == StFeed) ? a_sel : '0;
    o_b_col  = (state_q == StFeed) ? b_sel : '0;
    o_valid  = valid_q;
    o_C      = c_q;
  end

endmodule

// File: tb/tb_mm_seq.sv
// Bench for mm_seq: behavioural systolic array drives i_C, a job-level model predicts every
// output each cycle, and directed jobs pin latencies, skew values and results with literals.
module tb_mm_seq;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int NN = W * N * N;
  localparam int NR = W * N;

  logic          clk = 1'b0;
  logic          i_rst, i_en, i_mode, i_valid, i_ready;
  logic          o_ready, o_pe_en, o_pe_clr, o_valid, o_busy;
  logic [NN-1:0] i_A, i_B, i_C, o_C;
  logic [NR-1:0] o_a_row, o_b_col;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mm_seq #(.W(W), .N(N)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_mode   (i_mode),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_A      (i_A),
    .i_B      (i_B),
    .o_a_row  (o_a_row),
    .o_b_col  (o_b_col),
    .o_pe_en  (o_pe_en),
    .o_pe_clr (o_pe_clr),
    .i_C      (i_C),
    .o_C      (o_C),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_busy   (o_busy)
  );

  task automatic chk(input string name, input logic [NN-1:0] act, input logic [NN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- systolic array environment ----------------
  logic [W-1:0] pa [N][N];
  logic [W-1:0] pb [N][N];
  logic [W-1:0] acc[N][N];

  function automatic logic [W-1:0] ain(input int i, input int j);
    return (j == 0) ? o_a_row[i*W +: W] : pa[i][j-1];
  endfunction

  function automatic logic [W-1:0] bin(input int i, input int j);
    return (i == 0) ? o_b_col[j*W +: W] : pb[i-1][j];
  endfunction

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pa[i][j]  = '0;
        pb[i][j]  = '0;
        acc[i][j] = '0;
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (o_pe_clr) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else if (o_pe_en) begin
          acc[i][j] <= acc[i][j] + W'(ain(i, j) * bin(i, j));
          pa[i][j]  <= ain(i, j);
          pb[i][j]  <= bin(i, j);
        end
      end
  end

  always_comb begin
    i_C = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        i_C[(i*N+j)*W +: W] = acc[i][j];
  end

  // ---------------- job-level reference model ----------------
  function automatic logic [NN-1:0] matmul(input logic [NN-1:0] a, input logic [NN-1:0] b,
                                            input logic [NN-1:0] base);
    logic [NN-1:0] r;
    logic [W-1:0]  s;
    r = '0;
    for (int ri = 0; ri < N; ri++)
      for (int ci = 0; ci < N; ci++) begin
        s = base[(ri*N+ci)*W +: W];
        for (int t = 0; t < N; t++)
          s = s + W'(a[(ri*N+t)*W +: W] * b[(t*N+ci)*W +: W]);
        r[(ri*N+ci)*W +: W] = s;
      end
    return r;
  endfunction

  // m_ph: 0 idle, 1 running, 2 result held. m_rem: enabled edges left until the result.
  bit            m_init = 1'b0;
  int            m_ph   = 0;
  int            m_rem  = 0;
  logic          m_valid = 1'b0;
  logic [NN-1:0] m_a = '0, m_b = '0, m_c = '0, m_next = '0;

  always @(posedge clk) begin
    if (i_rst) begin
      m_init  <= 1'b1;
      m_ph    <= 0;
      m_rem   <= 0;
      m_valid <= 1'b0;
      m_c     <= '0;
      m_a     <= '0;
      m_b     <= '0;
    end else if (i_en) begin
      if (m_ph == 0) begin
        if (i_valid) begin
          m_ph   <= 1;
          m_rem  <= i_mode ? 3 * N - 1 : 3 * N;
          m_a    <= i_A;
          m_b    <= i_B;
          m_next <= matmul(i_A, i_B, i_mode ? m_c : '0);
        end
      end else if (m_ph == 1) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_ph    <= 2;
          m_valid <= 1'b1;
          m_c     <= m_next;
        end
      end else if (i_ready) begin
        m_ph    <= 0;
        m_valid <= 1'b0;
      end
    end
  end

  // Expected edge lane values: the k-th wavefront of A rows / B columns during feeding.
  function automatic logic [NR-1:0] exp_edge(input logic [NN-1:0] m, input bit is_row);
    logic [NR-1:0] r;
    int k;
    int d;
    r = '0;
    if (m_ph == 1 && m_rem >= N + 1 && m_rem <= 3 * N - 1) begin
      k = 3 * N - 1 - m_rem;
      for (int i = 0; i < N; i++) begin
        d = k - i;
        if (d >= 0 && d < N)
          r[i*W +: W] = is_row ? m[(i*N+d)*W +: W] : m[(d*N+i)*W +: W];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      chk("mon_ready",  o_ready,  (m_ph == 0) && i_en);
      chk("mon_busy",   o_busy,   m_ph != 0);
      chk("mon_valid",  o_valid,  m_valid);
      chk("mon_pe_en",  o_pe_en,  i_en && m_ph == 1 && m_rem >= 2 && m_rem <= 3 * N - 1);
      chk("mon_pe_clr", o_pe_clr, i_en && m_ph == 1 && m_rem == 3 * N);
      chk("mon_a_row",  o_a_row,  exp_edge(m_a, 1'b1));
      chk("mon_b_col",  o_b_col,  exp_edge(m_b, 1'b0));
      chk("mon_C",      o_C,      m_c);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one job, optionally stall i_en for 3 cycles from cycle stall_at, and wait for o_valid.
  task automatic run_job(input bit mode, input logic [NN-1:0] a, input logic [NN-1:0] b,
                         input int stall_at, input bit rdy, output int lat, output int clrs,
                         output logic [NR-1:0] r0, output logic [NR-1:0] c0,
                         output logic [NR-1:0] r4, output logic [NR-1:0] c4);
    i_A = a; i_B = b; i_mode = mode; i_valid = 1'b1; i_ready = rdy;
    tick();
    i_valid = 1'b0;
    i_A = ~a; i_B = ~b; i_mode = ~mode;
    lat = 0; clrs = 0; r0 = '0; c0 = '0; r4 = '0; c4 = '0;
    while (!o_valid && lat < 60) begin
      i_en = !(stall_at >= 0 && lat >= stall_at && lat < stall_at + 3);
      if (lat == 1) begin r0 = o_a_row; c0 = o_b_col; end
      if (lat == 5) begin r4 = o_a_row; c4 = o_b_col; end
      if (o_pe_clr) clrs++;
      tick();
      lat++;
    end
    i_en = 1'b1;
  endtask

  task automatic to_idle();
    int n;
    n = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (o_busy && n < 10) begin
      tick();
      n++;
    end
    chk("return_idle", o_busy, 1'b0);
  endtask

  logic [NN-1:0] ident, b9, b9x2, a2, c2, ra, rb;
  logic [NR-1:0] r0, c0, r4, c4;
  int            lat, clrs;

  initial begin
    ident = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
    b9    = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    b9x2  = {16'd18, 16'd16, 16'd14, 16'd12, 16'd10, 16'd8, 16'd6, 16'd4, 16'd2};
    a2    = {16'd4, 16'd1, 16'd0, 16'd0, 16'd3, 16'd1, 16'd1, 16'd0, 16'd2};
    c2    = {16'd42, 16'd37, 16'd32, 16'd21, 16'd17, 16'd13, 16'd15, 16'd12, 16'd9};

    i_rst = 1'b1; i_en = 1'b1; i_mode = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_A = '0; i_B = '0;
    tick();
    tick();
    chk("rst_C", o_C, '0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_pe_en", o_pe_en, 1'b0);
    chk("rst_pe_clr", o_pe_clr, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    i_rst = 1'b0;

    // Identity times 1..9, clear mode.
    run_job(1'b0, ident, b9, -1, 1'b1, lat, clrs, r0, c0, r4, c4);
    chk("j1_latency", lat, 9);
    chk("j1_C", o_C, b9);
    chk("j1_k0_row", r0, {16'd0, 16'd0, 16'd1});
    chk("j1_k0_col", c0, {16'd0, 16'd0, 16'd1});
    chk("j1_k4_row", r4, {16'd1, 16'd0, 16'd0});
    chk("j1_k4_col", c4, {16'd9, 16'd0, 16'd0});
    to_idle();

    // Same operands, accumulate mode.
    run_job(1'b1, ident, b9, -1, 1'b1, lat, clrs, r0, c0, r4, c4);
    chk("j2_latency", lat, 8);
    chk("j2_C", o_C, b9x2);
    chk("j2_no_clr", clrs, 0);
    to_idle();

    // Enable stalled for 3 cycles at feed step 2.
    run_job(1'b0, ident, b9, 3, 1'b1, lat, clrs, r0, c0, r4, c4);
    chk("j3_latency", lat, 12);
    chk("j3_C", o_C, b9);
    to_idle();

    // Result held with i_ready low while new requests are presented.
    run_job(1'b0, a2, b9, -1, 1'b0, lat, clrs, r0, c0, r4, c4);
    chk("j4_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      tick();
      chk("j4_hold_valid", o_valid, 1'b1);
      chk("j4_hold_C", o_C, c2);
      chk("j4_hold_ready", o_ready, 1'b0);
    end
    to_idle();

    // Reset in the middle of feeding, then a clean job.
    i_A = a2; i_B = b9; i_mode = 1'b0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    i_rst = 1'b1;
    tick();
    chk("j5_rst_busy", o_busy, 1'b0);
    chk("j5_rst_C", o_C, '0);
    chk("j5_rst_ready", o_ready, 1'b1);
    chk("j5_rst_valid", o_valid, 1'b0);
    i_rst = 1'b0;
    run_job(1'b0, ident, b9, -1, 1'b1, lat, clrs, r0, c0, r4, c4);
    chk("j5_latency", lat, 9);
    chk("j5_C", o_C, b9);
    to_idle();

    // Wide random operands (products wrap at W bits): clear job then accumulate job.
    for (int i = 0; i < N * N; i++) begin
      ra[i*W +: W] = W'($urandom);
      rb[i*W +: W] = W'($urandom);
    end
    run_job(1'b0, ra, rb, -1, 1'b1, lat, clrs, r0, c0, r4, c4);
    chk("j6_latency", lat, 9);
    to_idle();
    run_job(1'b1, rb, ra, 4, 1'b1, lat, clrs, r0, c0, r4, c4);
    chk("j7_latency", lat, 11);
    to_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
